// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipelined CPU hazard logic.
//   sb_entry_t  : one in-flight scoreboard slot {valid, wr_en, dst, is_load}
//   FWD_*       : operand-mux select encodings (0 = register file, k+1 = entry k)
//   NOP_INSN    : instruction word loaded into a killed pipeline register
// The dst field is sized for the widest register address supported
// (SB_AW_MAX). Narrower register files zero-extend into it.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int SB_AW_MAX = 8;

  localparam int FWD_RF  = 0;
  localparam int FWD_EX  = 1;
  localparam int FWD_MEM = 2;
  localparam int FWD_WR  = 3;

  localparam logic [31:0] NOP_INSN = 32'h0;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [SB_AW_MAX-1:0] dst;
    logic                 is_load;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
// DEPTH-deep shift register of in-flight instructions. Entry 0 is the
// instruction now in EX, entry k is EX+k. Every cycle each entry moves one
// slot older and the oldest drops off.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears all entries)
//   bubble     : load an empty slot into entry 0 instead of din
//   din        : instruction leaving ID
//   entries    : all slots, flattened, entry k at [k*SB_ENTRY_W +: SB_ENTRY_W]
// -----------------------------------------------------------------------------
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bubble,
  input  sb_entry_t                   din,
  output logic [DEPTH*SB_ENTRY_W-1:0] entries
);

  sb_entry_t sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else begin
      sr[0] <= bubble ? sb_entry_t'('0) : din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign entries[g*SB_ENTRY_W +: SB_ENTRY_W] = sr[g];
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
// Hazard control beside the ID stage: tracks in-flight destinations, selects
// operand forwarding, stalls on load-use, flushes IF/ID after a taken branch
// and counts stall cycles.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   id_valid                   : ID holds a real instruction
//   id_rs/id_rt, id_uses_rs/rt : ID source registers and whether they are read
//   id_wr_en, id_dst           : ID writes register id_dst
//   id_is_load                 : ID instruction is a load
//   ex_br_taken                : branch in EX resolved taken
//   stall                      : hold PC and IF/ID
//   bubble_ex                  : insert NOP into ID/EX (same as stall)
//   flush_ifid                 : zero the IF/ID instruction
//   fwd_a_sel/fwd_b_sel        : 0 = register file, k+1 = scoreboard entry k
//   stall_cnt                  : saturating count of stall cycles
// Build option HAZARD_FWD_EN: when defined, forwarding is enabled and only
// load-use within LOAD_LAT stalls. When undefined, the forward selects are 0
// and any in-flight producer of a used source stalls ID (pure interlock).
// Flush always overrides stall: the killed instruction never stalls.
// -----------------------------------------------------------------------------
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int BR_FLUSH   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [REG_AW-1:0]                 id_rs,
  input  logic [REG_AW-1:0]                 id_rt,
  input  logic                              id_uses_rs,
  input  logic                              id_uses_rt,
  input  logic                              id_wr_en,
  input  logic [REG_AW-1:0]                 id_dst,
  input  logic                              id_is_load,
  input  logic                              ex_br_taken,
  output logic                              stall,
  output logic                              bubble_ex,
  output logic                              flush_ifid,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_a_sel,
  output logic [$clog2(FWD_STAGES+1)-1:0]   fwd_b_sel,
  output logic [CNT_W-1:0]                  stall_cnt
);

  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  localparam int FC_W  = (BR_FLUSH > 0) ? $clog2(BR_FLUSH + 1) : 1;

  // ---------------- scoreboard ----------------
  logic [FWD_STAGES*SB_ENTRY_W-1:0] sb_flat;
  sb_entry_t                        ent [FWD_STAGES];
  sb_entry_t                        id_ent;
  logic                             sb_bubble;
  logic                             raw_stall;

  always_comb begin
    id_ent                 = '0;
    id_ent.valid           = 1'b1;
    id_ent.wr_en           = id_wr_en;
    id_ent.dst[REG_AW-1:0] = id_dst;
    id_ent.is_load         = id_is_load;
  end

  // A stalled or killed ID instruction stays out of the pipe this cycle.
  assign sb_bubble = ~(id_valid & ~stall & ~flush_ifid);

  pipe_scoreboard #(.DEPTH(FWD_STAGES)) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (sb_bubble),
    .din     (id_ent),
    .entries (sb_flat)
  );

  for (genvar g = 0; g < FWD_STAGES; g++) begin : g_unpack
    assign ent[g] = sb_entry_t'(sb_flat[g*SB_ENTRY_W +: SB_ENTRY_W]);
  end

  // Register 0 is hard-wired zero and never has a producer.
  function automatic logic sb_match(input sb_entry_t e, input logic [REG_AW-1:0] r);
    logic [SB_AW_MAX-1:0] rx;
    rx             = '0;
    rx[REG_AW-1:0] = r;
    return e.valid && e.wr_en && (e.dst == rx) && (r != '0);
  endfunction

`ifdef HAZARD_FWD_EN
  logic [SEL_W-1:0] a_sel, b_sel;
  logic             a_load, b_load;

  // Scan oldest to youngest so the youngest producer overwrites the result.
  always_comb begin
    a_sel  = SEL_W'(FWD_RF);
    b_sel  = SEL_W'(FWD_RF);
    a_load = 1'b0;
    b_load = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (id_uses_rs && sb_match(ent[k], id_rs)) begin
        a_sel  = SEL_W'(FWD_EX + k);
        a_load = ent[k].is_load && (k < LOAD_LAT);
      end
      if (id_uses_rt && sb_match(ent[k], id_rt)) begin
        b_sel  = SEL_W'(FWD_EX + k);
        b_load = ent[k].is_load && (k < LOAD_LAT);
      end
    end
  end

  assign fwd_a_sel = a_sel;
  assign fwd_b_sel = b_sel;
  assign raw_stall = a_load | b_load;
`else
  logic a_hit, b_hit;
  logic unused_load;

  always_comb begin
    a_hit       = 1'b0;
    b_hit       = 1'b0;
    unused_load = id_is_load;
    for (int k = 0; k < FWD_STAGES; k++) begin
      a_hit       = a_hit | (id_uses_rs && sb_match(ent[k], id_rs));
      b_hit       = b_hit | (id_uses_rt && sb_match(ent[k], id_rt));
      unused_load = unused_load ^ ent[k].is_load;
    end
  end

  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
  assign raw_stall = a_hit | b_hit;
`endif

  // ---------------- branch flush ----------------
  logic [FC_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (ex_br_taken) begin
      flush_cnt <= FC_W'(BR_FLUSH);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  assign flush_ifid = (flush_cnt != '0) | ex_br_taken;
  assign stall      = raw_stall & ~flush_ifid;
  assign bubble_ex  = stall;

  // ---------------- stall statistics ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int REG_AW     = 5;
  localparam int FWD_STAGES = 3;
  localparam int LOAD_LAT   = 1;
  localparam int BR_FLUSH   = 2;
  localparam int CNT_W      = 6;
  localparam int SEL_W      = $clog2(FWD_STAGES + 1);
  localparam int OBS_W      = 3 + 2*SEL_W + CNT_W;

`ifdef HAZARD_FWD_EN
  localparam int LU_STALLS = 1;
`else
  localparam int LU_STALLS = 3;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, ex_br_taken;
  logic [REG_AW-1:0] id_rs, id_rt, id_dst;
  logic              stall, bubble_ex, flush_ifid;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_hazard_unit #(
    .REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .LOAD_LAT(LOAD_LAT),
    .BR_FLUSH(BR_FLUSH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_dst(id_dst), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .stall(stall), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );

  logic [OBS_W-1:0] obs_vec, exp_vec;
  assign obs_vec = {stall, bubble_ex, flush_ifid, fwd_a_sel, fwd_b_sel, stall_cnt};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // History of instructions that left ID, tagged with the cycle they left.
  // An instruction that left ID in cycle t is age (now - t - 1) cycles past EX.
  typedef struct {
    int                cyc;
    logic              wr;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } rec_t;

  rec_t hist[$];
  int   cyc     = 0;
  int   last_br = -1000;
  int   m_cnt   = 0;
  logic e_stall, e_flush;
  logic [SEL_W-1:0] e_fa, e_fb;

  task automatic model_eval();
    int   age_a = FWD_STAGES;
    int   age_b = FWD_STAGES;
    logic ld_a  = 1'b0;
    logic ld_b  = 1'b0;
    logic raw;
    e_flush = ex_br_taken || ((cyc - last_br >= 1) && (cyc - last_br <= BR_FLUSH));
    foreach (hist[i]) begin
      int age;
      age = cyc - hist[i].cyc - 1;
      if (age >= 0 && age < FWD_STAGES && hist[i].wr) begin
        if (id_uses_rs && id_rs != 0 && hist[i].dst == id_rs && age < age_a) begin
          age_a = age; ld_a = hist[i].ld;
        end
        if (id_uses_rt && id_rt != 0 && hist[i].dst == id_rt && age < age_b) begin
          age_b = age; ld_b = hist[i].ld;
        end
      end
    end
`ifdef HAZARD_FWD_EN
    e_fa = (age_a < FWD_STAGES) ? SEL_W'(age_a + 1) : '0;
    e_fb = (age_b < FWD_STAGES) ? SEL_W'(age_b + 1) : '0;
    raw  = (ld_a && age_a < LOAD_LAT) || (ld_b && age_b < LOAD_LAT);
`else
    e_fa = '0;
    e_fb = '0;
    raw  = (age_a < FWD_STAGES) || (age_b < FWD_STAGES) || (ld_a && ld_b && 1'b0);
`endif
    e_stall = raw && !e_flush;
    exp_vec = {e_stall, e_stall, e_flush, e_fa, e_fb, CNT_W'(m_cnt)};
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      hist.delete();
      last_br = -1000;
      m_cnt   = 0;
    end else begin
      if (e_stall && m_cnt < (2**CNT_W - 1)) m_cnt++;
      if (id_valid && !e_stall && !e_flush)
        hist.push_back('{cyc, id_wr_en, id_dst, id_is_load});
      if (ex_br_taken) last_br = cyc;
    end
    while (hist.size() > 0 && cyc - hist[0].cyc >= FWD_STAGES) void'(hist.pop_front());
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rs;
    logic              urs;
    logic [REG_AW-1:0] rt;
    logic              urt;
    logic              wr;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } insn_t;

  function automatic insn_t mk(bit v, int rs, bit urs, int rt, bit urt, bit wr, int dst, bit ld);
    insn_t i;
    i.v = v; i.rs = REG_AW'(rs); i.urs = urs; i.rt = REG_AW'(rt); i.urt = urt;
    i.wr = wr; i.dst = REG_AW'(dst); i.ld = ld;
    return i;
  endfunction

  task automatic drive(insn_t i);
    id_valid = i.v; id_rs = i.rs; id_uses_rs = i.urs; id_rt = i.rt;
    id_uses_rt = i.urt; id_wr_en = i.wr; id_dst = i.dst; id_is_load = i.ld;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int n);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < n; c++) begin
      sample();
      advance();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ex_br_taken = 1'b0;
    idle(3);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sample();
      checks++;
      if (obs_vec !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs_vec);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_forward();
    insn_t prog[8];
    int    spot[8];
    prog[0] = mk(1, 0, 0, 0, 0, 1, 3, 0);   // add $3
    prog[1] = mk(1, 3, 1, 7, 1, 1, 8, 0);   // sub $8,$3,$7
    prog[2] = mk(1, 3, 1, 0, 0, 1, 10, 0);  // reads $3 one cycle later
    prog[3] = mk(1, 0, 0, 0, 0, 1, 3, 0);   // producer of $3 (ends at k=2)
    prog[4] = mk(1, 0, 0, 0, 0, 1, 9, 0);
    prog[5] = mk(1, 0, 0, 0, 0, 1, 3, 0);   // producer of $3 (k=0)
    prog[6] = mk(1, 3, 1, 0, 0, 1, 11, 0);  // reader with two producers
    prog[7] = mk(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    spot = '{-1, 1, 2, -1, -1, -1, 1, -1};
`else
    spot = '{-1, 0, -1, -1, -1, -1, 0, -1};
`endif
    idle(4);
    for (int p = 0; p < 8; p++) begin
      drive(prog[p]);
      for (int n = 0; n < 8; n++) begin
        sample();
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL forward p=%0d cyc=%0d got=%h exp=%h", p, cyc, obs_vec, exp_vec);
        end
        if (n == 0 && spot[p] >= 0) begin
          checks++;
          if (fwd_a_sel !== SEL_W'(spot[p])) begin
            errors++;
            $display("FAIL forward_sel p=%0d got=%0d exp=%0d", p, fwd_a_sel, spot[p]);
          end
        end
        advance();
        if (!e_stall) break;
        if (n == 7) begin
          errors++;
          $display("FAIL forward_timeout p=%0d got=stalled exp=release", p);
        end
      end
    end
  endtask

  task automatic test_load_use();
    int stalls_seen = 0;
    int cnt_before;
    idle(4);
    cnt_before = m_cnt;
    drive(mk(1, 0, 0, 0, 0, 1, 5, 1));      // lw $5
    sample();
    advance();
    drive(mk(1, 1, 1, 5, 1, 1, 6, 0));      // add $6,$1,$5
    for (int n = 0; n < 8; n++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL load_use cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (stall) stalls_seen++;
`ifdef HAZARD_FWD_EN
      if (n == 1) begin
        checks++;
        if (fwd_b_sel !== SEL_W'(2) || stall !== 1'b0) begin
          errors++;
          $display("FAIL load_use_fwd got sel=%0d stall=%b exp sel=2 stall=0", fwd_b_sel, stall);
        end
      end
`endif
      advance();
      if (!e_stall) break;
    end
    checks++;
    if (stalls_seen != LU_STALLS) begin
      errors++;
      $display("FAIL load_use_len got=%0d exp=%0d", stalls_seen, LU_STALLS);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    sample();
    checks++;
    if (stall_cnt !== CNT_W'(cnt_before + LU_STALLS)) begin
      errors++;
      $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cnt, cnt_before + LU_STALLS);
    end
    advance();
  endtask

  task automatic test_zero_reg();
    idle(4);
    drive(mk(1, 0, 0, 0, 0, 1, 0, 1));      // lw $0
    sample();
    advance();
    drive(mk(1, 0, 1, 0, 1, 1, 4, 0));      // reads $0 twice
    for (int n = 0; n < 2; n++) begin
      sample();
      checks++;
      if (stall !== 1'b0 || fwd_a_sel !== '0 || fwd_b_sel !== '0) begin
        errors++;
        $display("FAIL zero_reg got stall=%b a=%0d b=%0d exp stall=0 a=0 b=0",
                 stall, fwd_a_sel, fwd_b_sel);
      end
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL zero_reg_model cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    int flush_seen = 0;
    int stall_seen = 0;
    idle(4);
    drive(mk(1, 0, 0, 0, 0, 1, 5, 1));      // lw $5
    sample();
    advance();
    drive(mk(1, 0, 0, 5, 1, 1, 6, 0));      // load-use consumer, killed by flush
    ex_br_taken = 1'b1;
    for (int n = 0; n < 6; n++) begin
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL branch cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (flush_ifid) flush_seen++;
      if (stall) stall_seen++;
      advance();
      ex_br_taken = 1'b0;
    end
    checks++;
    if (flush_seen != BR_FLUSH + 1 || stall_seen != 0) begin
      errors++;
      $display("FAIL branch_window got flush=%0d stall=%0d exp flush=%0d stall=0",
               flush_seen, stall_seen, BR_FLUSH + 1);
    end
    // back-to-back branch reloads the window
    flush_seen = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 8; n++) begin
      ex_br_taken = (n == 0 || n == 2);
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL branch_reload cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      if (flush_ifid) flush_seen++;
      advance();
    end
    ex_br_taken = 1'b0;
    checks++;
    if (flush_seen != BR_FLUSH + 3) begin
      errors++;
      $display("FAIL branch_reload_len got=%0d exp=%0d", flush_seen, BR_FLUSH + 3);
    end
  endtask

  task automatic test_reset_mid_op();
    idle(4);
    drive(mk(1, 0, 0, 0, 0, 1, 5, 1));      // lw $5
    sample();
    advance();
    drive(mk(1, 0, 0, 5, 1, 1, 6, 0));
    rst_n = 1'b0;
    sample();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_stall got=%b exp=1", stall);
    end
    advance();
    rst_n = 1'b1;
    sample();
    checks++;
    if (stall !== 1'b0 || bubble_ex !== 1'b0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall got stall=%b bubble=%b cnt=%0d exp 0 0 0",
               stall, bubble_ex, stall_cnt);
    end
    advance();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    ex_br_taken = 1'b1;
    sample();
    advance();
    ex_br_taken = 1'b0;
    rst_n = 1'b0;
    sample();
    checks++;
    if (flush_ifid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_flush got=%b exp=1", flush_ifid);
    end
    advance();
    rst_n = 1'b1;
    sample();
    checks++;
    if (obs_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush got=%h exp=0", obs_vec);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(mk($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
               $urandom_range(0, 7), $urandom_range(0, 2) == 0));
      ex_br_taken = ($urandom_range(0, 7) == 0);
      sample();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
      end
      advance();
    end
    ex_br_taken = 1'b0;
  endtask

  task automatic test_saturate();
    for (int p = 0; p < 70; p++) begin
      drive(mk(1, 0, 0, 0, 0, 1, 5, 1));
      sample();
      advance();
      drive(mk(1, 0, 0, 5, 1, 1, 6, 0));
      for (int n = 0; n < 8; n++) begin
        sample();
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL saturate p=%0d cyc=%0d got=%h exp=%h", p, cyc, obs_vec, exp_vec);
        end
        advance();
        if (!e_stall) break;
      end
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    sample();
    checks++;
    if (stall_cnt !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL saturate_cnt got=%0d exp=%0d", stall_cnt, 2**CNT_W - 1);
    end
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    ex_br_taken = 1'b0;
    test_reset();
    test_forward();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_reset_mid_op();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
